// File: rtl/dest_reg_tracker_pkg.sv
// Shared pipeline definitions for the destination-register tracker: ID width,
// load-flag bit positions and the per-stage entry layout.
package dest_reg_tracker_pkg;

    localparam int IDW   = 3;
    localparam int NFLAG = 5;

    // Bit positions inside an entry's load-flag vector.
    localparam int LDF_GPR1 = 0;
    localparam int LDF_GPR2 = 1;
    localparam int LDF_SEG  = 2;
    localparam int LDF_CSEG = 3;
    localparam int LDF_MM   = 4;

    typedef logic [IDW-1:0]   drid_t;
    typedef logic [NFLAG-1:0] ldf_t;

    typedef struct packed {
        drid_t drid1;
        drid_t drid2;
        ldf_t  ld;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic entry_t make_entry(input drid_t drid1, input drid_t drid2, input ldf_t ld);
        entry_t e;
        e.drid1 = drid1;
        e.drid2 = drid2;
        e.ld    = ld;
        return e;
    endfunction

endpackage

// File: rtl/dest_reg_tracker_stage.sv
// One pipeline slot: valid bit plus entry register, with flag outputs qualified by valid.
// Latency: loads on the edge where load=1; holds while neither leave nor clr; clr wins over load.
module drid_stage_reg
    import dest_reg_tracker_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   load,
    input  logic   leave,
    input  entry_t entry_in,
    output logic   vld,
    output entry_t entry,
    output ldf_t   v_ld
);

    logic   vld_d;
    logic   vld_q;
    entry_t entry_d;
    entry_t entry_q;

    always_comb begin
        vld_d   = vld_q;
        entry_d = entry_q;
        if (clr) begin
            vld_d = 1'b0;
        end else begin
            vld_d = load | (vld_q & ~leave);
            if (load) begin
                entry_d = entry_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            entry_q <= '0;
        end else begin
            vld_q   <= vld_d;
            entry_q <= entry_d;
        end
    end

    assign vld   = vld_q;
    assign entry = entry_q;
    assign v_ld  = {NFLAG{vld_q}} & entry_q.ld;

endmodule

// File: rtl/dest_reg_tracker.sv
// Carries destination IDs and load flags of issued instructions through AG -> ME -> EX and retires to WB.
// Latency: issue at edge N shows in AG after N, EX after N+2; bubbles collapse, WB_STALL backpressures to RR_READY.
module dest_reg_tracker
    import dest_reg_tracker_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             RR_V,
    input  logic             DEP_STALL,
    input  logic [IDW-1:0]   RR_DRID1,
    input  logic [IDW-1:0]   RR_DRID2,
    input  logic [NFLAG-1:0] RR_LD,
    output logic             RR_READY,
    output logic [IDW-1:0]   AG_DRID1,
    output logic [IDW-1:0]   AG_DRID2,
    output logic [IDW-1:0]   ME_DRID1,
    output logic [IDW-1:0]   ME_DRID2,
    output logic [IDW-1:0]   EX_DRID1,
    output logic [IDW-1:0]   EX_DRID2,
    output logic             V_AG_LD_GPR1,
    output logic             V_AG_LD_GPR2,
    output logic             V_AG_LD_SEG,
    output logic             V_AG_LD_CSEG,
    output logic             V_AG_LD_MM,
    output logic             V_ME_LD_GPR1,
    output logic             V_ME_LD_GPR2,
    output logic             V_ME_LD_SEG,
    output logic             V_ME_LD_CSEG,
    output logic             V_ME_LD_MM,
    output logic             V_EX_LD_GPR1,
    output logic             V_EX_LD_GPR2,
    output logic             V_EX_LD_SEG,
    output logic             V_EX_LD_CSEG,
    output logic             V_EX_LD_MM,
    output logic             WB_V,
    input  logic             WB_STALL,
    output logic [IDW-1:0]   WB_DRID1,
    output logic [IDW-1:0]   WB_DRID2,
    output logic [NFLAG-1:0] WB_LD,
    output logic             PIPE_BUSY
);

    logic   ag_v, me_v, ex_v;
    entry_t ag_e, me_e, ex_e;
    ldf_t   ag_vld_ld, me_vld_ld, ex_vld_ld;
    entry_t rr_e;

    logic ex_go, ex_free;
    logic me_go, me_free;
    logic ag_go, ag_free;
    logic issue;

    // Each stage frees up in the same cycle its occupant moves on, so a
    // retiring EX lets every upstream stage shift and RR issue at full rate.
    always_comb begin
        ex_go   = ex_v & ~WB_STALL;
        ex_free = ~ex_v | ex_go;
        me_go   = me_v & ex_free;
        me_free = ~me_v | me_go;
        ag_go   = ag_v & me_free;
        ag_free = ~ag_v | ag_go;
        issue   = RR_V & ~DEP_STALL & ag_free & ~FLUSH;
        rr_e    = make_entry(RR_DRID1, RR_DRID2, RR_LD);
    end

    drid_stage_reg u_ag (
        .clk      (CLK),
        .rst      (RST),
        .clr      (FLUSH),
        .load     (issue),
        .leave    (ag_go),
        .entry_in (rr_e),
        .vld      (ag_v),
        .entry    (ag_e),
        .v_ld     (ag_vld_ld)
    );

    drid_stage_reg u_me (
        .clk      (CLK),
        .rst      (RST),
        .clr      (FLUSH),
        .load     (ag_go),
        .leave    (me_go),
        .entry_in (ag_e),
        .vld      (me_v),
        .entry    (me_e),
        .v_ld     (me_vld_ld)
    );

    drid_stage_reg u_ex (
        .clk      (CLK),
        .rst      (RST),
        .clr      (FLUSH),
        .load     (me_go),
        .leave    (ex_go),
        .entry_in (me_e),
        .vld      (ex_v),
        .entry    (ex_e),
        .v_ld     (ex_vld_ld)
    );

    assign RR_READY  = ag_free;
    assign PIPE_BUSY = ag_v | me_v | ex_v;

    assign AG_DRID1 = ag_e.drid1;
    assign AG_DRID2 = ag_e.drid2;
    assign ME_DRID1 = me_e.drid1;
    assign ME_DRID2 = me_e.drid2;
    assign EX_DRID1 = ex_e.drid1;
    assign EX_DRID2 = ex_e.drid2;

    assign V_AG_LD_GPR1 = ag_vld_ld[LDF_GPR1];
    assign V_AG_LD_GPR2 = ag_vld_ld[LDF_GPR2];
    assign V_AG_LD_SEG  = ag_vld_ld[LDF_SEG];
    assign V_AG_LD_CSEG = ag_vld_ld[LDF_CSEG];
    assign V_AG_LD_MM   = ag_vld_ld[LDF_MM];

    assign V_ME_LD_GPR1 = me_vld_ld[LDF_GPR1];
    assign V_ME_LD_GPR2 = me_vld_ld[LDF_GPR2];
    assign V_ME_LD_SEG  = me_vld_ld[LDF_SEG];
    assign V_ME_LD_CSEG = me_vld_ld[LDF_CSEG];
    assign V_ME_LD_MM   = me_vld_ld[LDF_MM];

    assign V_EX_LD_GPR1 = ex_vld_ld[LDF_GPR1];
    assign V_EX_LD_GPR2 = ex_vld_ld[LDF_GPR2];
    assign V_EX_LD_SEG  = ex_vld_ld[LDF_SEG];
    assign V_EX_LD_CSEG = ex_vld_ld[LDF_CSEG];
    assign V_EX_LD_MM   = ex_vld_ld[LDF_MM];

    // Writeback sees the EX slot directly; flags are not gated by valid here.
    assign WB_V     = ex_v;
    assign WB_DRID1 = ex_e.drid1;
    assign WB_DRID2 = ex_e.drid2;
    assign WB_LD    = ex_e.ld;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed vector bench for dest_reg_tracker; each vector is one cycle of inputs and expected outputs.
module tb_dest_reg_tracker;
    import dest_reg_tracker_pkg::*;

    localparam logic [4:0] G1 = 5'b00001;
    localparam logic [4:0] G2 = 5'b00010;
    localparam logic [4:0] SG = 5'b00100;
    localparam logic [4:0] CS = 5'b01000;
    localparam logic [4:0] MM = 5'b10000;

    logic CLK = 1'b0;
    logic RST, FLUSH, RR_V, DEP_STALL, WB_STALL;
    logic [IDW-1:0] RR_DRID1, RR_DRID2;
    logic [NFLAG-1:0] RR_LD;
    logic RR_READY, WB_V, PIPE_BUSY;
    logic [IDW-1:0] AG_DRID1, AG_DRID2, ME_DRID1, ME_DRID2, EX_DRID1, EX_DRID2, WB_DRID1, WB_DRID2;
    logic [NFLAG-1:0] WB_LD;
    logic V_AG_LD_GPR1, V_AG_LD_GPR2, V_AG_LD_SEG, V_AG_LD_CSEG, V_AG_LD_MM;
    logic V_ME_LD_GPR1, V_ME_LD_GPR2, V_ME_LD_SEG, V_ME_LD_CSEG, V_ME_LD_MM;
    logic V_EX_LD_GPR1, V_EX_LD_GPR2, V_EX_LD_SEG, V_EX_LD_CSEG, V_EX_LD_MM;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 CLK = ~CLK;

    dest_reg_tracker dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .RR_V(RR_V), .DEP_STALL(DEP_STALL),
        .RR_DRID1(RR_DRID1), .RR_DRID2(RR_DRID2), .RR_LD(RR_LD), .RR_READY(RR_READY),
        .AG_DRID1(AG_DRID1), .AG_DRID2(AG_DRID2), .ME_DRID1(ME_DRID1), .ME_DRID2(ME_DRID2),
        .EX_DRID1(EX_DRID1), .EX_DRID2(EX_DRID2),
        .V_AG_LD_GPR1(V_AG_LD_GPR1), .V_AG_LD_GPR2(V_AG_LD_GPR2), .V_AG_LD_SEG(V_AG_LD_SEG),
        .V_AG_LD_CSEG(V_AG_LD_CSEG), .V_AG_LD_MM(V_AG_LD_MM),
        .V_ME_LD_GPR1(V_ME_LD_GPR1), .V_ME_LD_GPR2(V_ME_LD_GPR2), .V_ME_LD_SEG(V_ME_LD_SEG),
        .V_ME_LD_CSEG(V_ME_LD_CSEG), .V_ME_LD_MM(V_ME_LD_MM),
        .V_EX_LD_GPR1(V_EX_LD_GPR1), .V_EX_LD_GPR2(V_EX_LD_GPR2), .V_EX_LD_SEG(V_EX_LD_SEG),
        .V_EX_LD_CSEG(V_EX_LD_CSEG), .V_EX_LD_MM(V_EX_LD_MM),
        .WB_V(WB_V), .WB_STALL(WB_STALL), .WB_DRID1(WB_DRID1), .WB_DRID2(WB_DRID2),
        .WB_LD(WB_LD), .PIPE_BUSY(PIPE_BUSY)
    );

    typedef struct {
        logic rst, fl, rv, dep, wbs;
        logic [IDW-1:0] d1, d2;
        logic [NFLAG-1:0] ld;
        logic rdy, busy, wbv;
        logic [NFLAG-1:0] vag, vme, vex;
        logic [2:0] msk;
        logic [IDW-1:0] ag1, me1, ex1, ex2;
        logic [NFLAG-1:0] exld;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rst, fl, rv, dep, wbs, d1, d2, input logic [4:0] ld,
                                input int rdy, busy, wbv, input logic [4:0] vag, vme, vex,
                                input int msk, ag1, me1, ex1, ex2, input logic [4:0] exld);
        vec_t v;
        v.rst = (rst != 0); v.fl = (fl != 0); v.rv = (rv != 0); v.dep = (dep != 0); v.wbs = (wbs != 0);
        v.d1 = IDW'(d1); v.d2 = IDW'(d2); v.ld = ld;
        v.rdy = (rdy != 0); v.busy = (busy != 0); v.wbv = (wbv != 0);
        v.vag = vag; v.vme = vme; v.vex = vex;
        v.msk = 3'(msk); v.ag1 = IDW'(ag1); v.me1 = IDW'(me1); v.ex1 = IDW'(ex1); v.ex2 = IDW'(ex2);
        v.exld = exld;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, want);
    endtask

    function automatic logic [17:0] ctl();
        return {RR_READY, PIPE_BUSY, WB_V,
                V_AG_LD_MM, V_AG_LD_CSEG, V_AG_LD_SEG, V_AG_LD_GPR2, V_AG_LD_GPR1,
                V_ME_LD_MM, V_ME_LD_CSEG, V_ME_LD_SEG, V_ME_LD_GPR2, V_ME_LD_GPR1,
                V_EX_LD_MM, V_EX_LD_CSEG, V_EX_LD_SEG, V_EX_LD_GPR2, V_EX_LD_GPR1};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic found;

        // Reset held two cycles with a valid RR instruction that must not be captured.
        RST = 1'b1; FLUSH = 1'b0; RR_V = 1'b1; DEP_STALL = 1'b0; WB_STALL = 1'b0;
        RR_DRID1 = 3'd7; RR_DRID2 = 3'd7; RR_LD = 5'h1f;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        check("rst_ctl", 0, 32'(ctl()), 32'h20000);
        check("rst_ids", 0, 32'({AG_DRID1, ME_DRID1, EX_DRID1, AG_DRID2}), 32'h0);
        check("rst_wbld", 0, 32'(WB_LD), 32'h0);

        //      rst fl rv dp ws d1 d2 ld   rdy bsy wbv vag vme vex  msk ag me ex ex2 exld
        vecs.push_back(mk(0,0,1,0,0, 3,0,G1, 1,0,0, 0, 0, 0,  7,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,  1,1,0, G1,0, 0,  7,3,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,  1,1,0, 0, G1,0,  7,3,3,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,  1,1,1, 0, 0, G1, 7,3,3,3,0,G1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,  1,0,0, 0, 0, 0,  7,3,3,3,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 1,0,G1, 1,0,0, 0, 0, 0,  7,3,3,3,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 2,0,G1, 1,1,0, G1,0, 0,  7,1,3,3,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 3,0,G1, 1,1,0, G1,G1,0,  7,2,1,3,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 4,0,G1, 1,1,1, G1,G1,G1, 7,3,2,1,0,G1));
        vecs.push_back(mk(0,0,1,0,1, 5,0,G1, 0,1,1, G1,G1,G1, 7,4,3,2,0,G1));
        vecs.push_back(mk(0,0,1,0,1, 5,0,G1, 0,1,1, G1,G1,G1, 7,4,3,2,0,G1));
        vecs.push_back(mk(0,0,1,0,1, 5,0,G1, 0,1,1, G1,G1,G1, 7,4,3,2,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 5,0,G1, 1,1,1, G1,G1,G1, 7,4,3,2,0,G1));
        vecs.push_back(mk(0,0,1,1,0, 6,0,G1, 1,1,1, G1,G1,G1, 7,5,4,3,0,G1));
        vecs.push_back(mk(0,0,1,1,0, 6,0,G1, 1,1,1, 0, G1,G1, 7,5,5,4,0,G1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,  1,1,1, 0, 0, G1, 7,5,5,5,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 1,5,G2, 1,0,0, 0, 0, 0,  7,5,5,5,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 2,0,SG, 1,1,0, G2,0, 0,  7,1,5,5,0,G1));
        vecs.push_back(mk(0,0,1,0,0, 6,0,MM, 1,1,0, SG,G2,0,  7,2,1,5,0,G1));
        vecs.push_back(mk(0,1,1,0,0, 7,0,G1, 1,1,1, MM,SG,G2, 7,6,2,1,5,G2));
        vecs.push_back(mk(0,0,1,0,0, 4,0,CS, 1,0,0, 0, 0, 0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,  1,1,0, CS,0, 0,  4,4,0,0,0,0));
        vecs.push_back(mk(1,1,1,0,0, 7,0,G1, 1,1,0, 0, CS,0,  6,4,4,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,  1,0,0, 0, 0, 0,  7,0,0,0,0,0));

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst; FLUSH = vecs[i].fl; RR_V = vecs[i].rv;
            DEP_STALL = vecs[i].dep; WB_STALL = vecs[i].wbs;
            RR_DRID1 = vecs[i].d1; RR_DRID2 = vecs[i].d2; RR_LD = vecs[i].ld;
            #1;
            check("ctl", i, 32'(ctl()),
                  32'({vecs[i].rdy, vecs[i].busy, vecs[i].wbv, vecs[i].vag, vecs[i].vme, vecs[i].vex}));
            if (vecs[i].msk[2]) check("ag_drid1", i, 32'(AG_DRID1), 32'(vecs[i].ag1));
            if (vecs[i].msk[1]) check("me_drid1", i, 32'(ME_DRID1), 32'(vecs[i].me1));
            if (vecs[i].msk[0]) begin
                check("ex_drid1", i, 32'(EX_DRID1), 32'(vecs[i].ex1));
                check("wb_drid1", i, 32'(WB_DRID1), 32'(vecs[i].ex1));
                check("wb_drid2", i, 32'(WB_DRID2), 32'(vecs[i].ex2));
                check("ex_drid2", i, 32'(EX_DRID2), 32'(vecs[i].ex2));
                check("wb_ld", i, 32'(WB_LD), 32'(vecs[i].exld));
            end
        end

        // Bounded wait for a single issued entry to reach writeback.
        @(negedge CLK);
        RST = 1'b0; FLUSH = 1'b0; DEP_STALL = 1'b0; WB_STALL = 1'b0;
        RR_V = 1'b1; RR_DRID1 = 3'd2; RR_DRID2 = 3'd0; RR_LD = G1;
        @(negedge CLK);
        RR_V = 1'b0;
        cnt = 1;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            #1;
            if (WB_V) found = 1'b1;
            else begin
                @(negedge CLK);
                cnt++;
            end
        end
        check("wb_latency", 0, 32'(cnt), 32'd3);
        check("wb_lat_drid1", 0, 32'(WB_DRID1), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
